// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared update
// datapath sweeps four virtual neurons per tick; spikes go to an event FIFO.
module lif_scheduler #(
  parameter int unsigned N_NEURONS  = 4,
  parameter int unsigned THRESHOLD  = 200,
  parameter int unsigned BIAS       = 200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [31:0] current_in,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_weight,
  output logic        busy,
  output logic        done,
  output logic        evt_valid,
  output logic [1:0]  evt_id,
  input  logic        evt_ready,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]  THR8  = 8'(THRESHOLD);
  localparam logic [7:0]  BIAS8 = 8'(BIAS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  state_t           state_q, state_nx;
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic             done_nx;
  logic             capture_c, update_c;

  logic [7:0] cur_q     [N_NEURONS];
  logic [7:0] weight_q  [N_NEURONS];
  logic [7:0] nrn_state [N_NEURONS];

  logic [7:0] sel_state_c, sel_cur_c, sel_w_c, prod_lo_c, upd_val_c;
  logic       spike_c;

  logic [1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             push_c, pop_c, full_c, accept_c, drop_c;

  // Sweep control: IDLE waits for tick, UPDATE walks the neuron index
  always_comb begin
    state_nx  = state_q;
    idx_nx    = idx_q;
    done_nx   = 1'b0;
    capture_c = 1'b0;
    update_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_nx  = S_UPDATE;
          idx_nx    = '0;
          capture_c = 1'b1;
        end
      end
      S_UPDATE: begin
        update_c = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_nx = S_IDLE;
          idx_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          idx_nx = IDX_W'(idx_q + 1'b1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state, index and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      done    <= done_nx;
      busy    <= (state_nx == S_UPDATE);
    end
  end

  // Shared multiply-add datapath selected by the sweep index
  always_comb begin
    sel_state_c = nrn_state[idx_q];
    sel_cur_c   = cur_q[idx_q];
    sel_w_c     = weight_q[idx_q];
    // an 8-bit result of the 8x8 product is exactly the product's low byte
    prod_lo_c   = sel_cur_c * sel_w_c;
    spike_c     = (sel_state_c >= THR8);
    upd_val_c   = prod_lo_c + BIAS8 + (sel_state_c >> 1);
  end

  // Current capture, weight writes and neuron state updates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        cur_q[i]     <= '0;
        weight_q[i]  <= '0;
        nrn_state[i] <= '0;
      end
    end else begin
      if (capture_c) begin
        for (int i = 0; i < N_NEURONS; i++) begin
          cur_q[i] <= current_in[8*i +: 8];
        end
      end
      if (cfg_we) begin
        weight_q[cfg_addr] <= cfg_weight;
      end
      if (update_c) begin
        nrn_state[idx_q] <= spike_c ? 8'd0 : upd_val_c;
      end
    end
  end

  // FIFO handshake; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    push_c   = update_c & spike_c;
    pop_c    = (fifo_cnt != '0) & evt_ready;
    full_c   = (fifo_cnt == FULL_CNT);
    accept_c = push_c & (~full_c | pop_c);
    drop_c   = push_c & full_c & ~pop_c;
  end

  // Event FIFO storage, pointers, occupancy and saturating counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      drop_cnt    <= '0;
      overrun_cnt <= '0;
    end else begin
      if (accept_c) begin
        fifo_mem[wr_ptr] <= idx_q;
        wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : PTR_W'(wr_ptr + 1'b1);
      end
      if (pop_c) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : PTR_W'(rd_ptr + 1'b1);
      end
      if (accept_c && !pop_c) begin
        fifo_cnt <= CNT_W'(fifo_cnt + 1'b1);
      end else if (!accept_c && pop_c) begin
        fifo_cnt <= CNT_W'(fifo_cnt - 1'b1);
      end
      if (drop_c && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      if ((state_q == S_UPDATE) && tick && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  assign evt_valid = (fifo_cnt != '0);
  assign evt_id    = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_lif_scheduler.sv
// Bench for lif_scheduler: sweep-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_lif_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] current_in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_weight = '0;
  logic        busy, done, evt_valid;
  logic [1:0]  evt_id;
  logic        evt_ready = 1'b1;
  logic [7:0]  drop_cnt, overrun_cnt;

  int n_cmp = 0;
  int n_err = 0;

  lif_scheduler dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .current_in(current_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight),
    .busy(busy), .done(done), .evt_valid(evt_valid), .evt_id(evt_id),
    .evt_ready(evt_ready), .drop_cnt(drop_cnt), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_pos = -1;              // neuron being updated next, -1 when idle
  int m_cur[4] = '{default: 0};
  int m_w[4] = '{default: 0};
  int m_state[4] = '{default: 0};
  int m_q[$];
  int m_drop = 0;
  int m_ovr = 0;
  bit m_done = 1'b0;
  int dut_pops[$];

  always @(posedge clk or negedge reset_n) begin
    int n, s;
    if (!reset_n) begin
      m_pos = -1; m_done = 1'b0; m_drop = 0; m_ovr = 0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
        m_cur[i] = 0; m_w[i] = 0; m_state[i] = 0;
      end
    end else begin
      m_done = 1'b0;
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      if (m_pos >= 0) begin
        if (tick && m_ovr < 255) m_ovr++;
        n = m_pos;
        s = m_state[n];
        if (s >= 200) begin
          m_state[n] = 0;
          if (m_q.size() < 4) m_q.push_back(n);
          else if (m_drop < 255) m_drop++;
        end else begin
          m_state[n] = (((m_cur[n] * m_w[n]) % 256) + 200 + s / 2) % 256;
        end
        if (n == 3) begin m_pos = -1; m_done = 1'b1; end
        else m_pos = n + 1;
      end else if (tick) begin
        for (int i = 0; i < 4; i++) m_cur[i] = int'(current_in[8*i +: 8]);
        m_pos = 0;
      end
      if (cfg_we) m_w[cfg_addr] = int'(cfg_weight);
    end
  end

  // Record events the DUT hands over (sampled before the edge takes effect)
  always @(posedge clk) begin
    if (reset_n && evt_valid && evt_ready) dut_pops.push_back(int'(evt_id));
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", int'(busy), (m_pos >= 0) ? 1 : 0);
    chk("done", int'(done), int'(m_done));
    chk("evt_valid", int'(evt_valid), (m_q.size() > 0) ? 1 : 0);
    if (m_q.size() > 0) chk("evt_id", int'(evt_id), m_q[0]);
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("overrun_cnt", int'(overrun_cnt), m_ovr);
    for (int i = 0; i < 4; i++) chk("nrn_state", int'(dut.nrn_state[i]), m_state[i]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick = 1'b0; cfg_we = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    dut_pops.delete();
  endtask

  task automatic sweep();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(5);
  endtask

  logic [31:0] ctab[8] = '{32'h0A_C8_64_01, 32'hFF_10_33_80, 32'h05_06_07_08, 32'h80_80_80_80,
                           32'h01_02_03_FF, 32'h7F_00_C0_11, 32'h22_44_66_88, 32'hFE_DC_BA_98};
  logic [7:0]  wtab[4] = '{8'd3, 8'd7, 8'd0, 8'd255};

  initial begin
    // Reset values
    cyc(2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_id", int'(evt_id), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_ovr", int'(overrun_cnt), 0);
    reset_n = 1'b1;

    // Zero weights/currents: charge to 200, then four spikes in index order
    evt_ready = 1'b1; current_in = '0;
    sweep();
    for (int i = 0; i < 4; i++) chk("pin_charge200", m_state[i], 200);
    chk("no_events_first_sweep", dut_pops.size(), 0);
    sweep(); cyc(2);
    chk("spike_count", dut_pops.size(), 4);
    if (dut_pops.size() == 4)
      for (int i = 0; i < 4; i++) chk("spike_order", dut_pops[i], i);
    for (int i = 0; i < 4; i++) chk("pin_cleared", m_state[i], 0);

    // Weight0 = 1, current0 = 100: 44 then 66, neuron 0 never spikes
    do_reset();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_weight = 8'd1; current_in = 32'd100;
    cyc(1); cfg_we = 1'b0;
    sweep();
    chk("pin_state0_44", m_state[0], 44);
    sweep(); cyc(2);
    chk("pin_state0_66", m_state[0], 66);
    chk("pops_no_n0", dut_pops.size(), 3);
    if (dut_pops.size() > 0) chk("first_pop_n1", dut_pops[0], 1);

    // Consumer stalled: 8 spikes, 4 kept, 4 dropped, states still cleared
    do_reset();
    evt_ready = 1'b0; current_in = '0;
    repeat (4) sweep();
    chk("stall_drop4", int'(drop_cnt), 4);
    chk("stall_valid", int'(evt_valid), 1);
    chk("stall_head0", int'(evt_id), 0);
    for (int i = 0; i < 4; i++) chk("pin_stall_cleared", m_state[i], 0);
    // Full FIFO with ready on spiking edges: push accepted alongside the pop
    sweep();
    tick = 1'b1; cyc(1); tick = 1'b0; evt_ready = 1'b1; cyc(8);
    chk("full_accept_drop", int'(drop_cnt), 4);
    chk("full_accept_pops", dut_pops.size(), 8);
    if (dut_pops.size() == 8)
      for (int i = 0; i < 8; i++) chk("full_accept_order", dut_pops[i], i % 4);

    // Tick held high: sweep every 5 cycles, 4 overruns per sweep
    do_reset();
    tick = 1'b1; cyc(15); tick = 1'b0; cyc(3);
    chk("overrun12", int'(overrun_cnt), 12);

    // Reset in the middle of a sweep, then a fresh sweep
    do_reset();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    reset_n = 1'b0; cyc(2);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_state0", int'(dut.nrn_state[0]), 0);
    chk("midrst_valid", int'(evt_valid), 0);
    reset_n = 1'b1; cyc(2);
    chk("midrst_no_resume", int'(busy), 0);
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("fresh_busy", int'(busy), 1);
    cyc(5);
    for (int i = 0; i < 4; i++) chk("pin_fresh200", m_state[i], 200);

    // Mixed currents/weights, mid-sweep current changes, same-edge weight writes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_addr = 2'(i); cfg_weight = wtab[i]; cyc(1);
    end
    cfg_we = 1'b0;
    for (int s = 0; s < 8; s++) begin
      current_in = ctab[s];
      tick = 1'b1; cyc(1); tick = 1'b0;
      current_in = ~ctab[s]; evt_ready = 1'((s % 2) == 1);
      cyc(1);
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_weight = 8'(s * 13 + 5);
      cyc(1); cfg_we = 1'b0;
      cyc(3);
    end
    evt_ready = 1'b1; cyc(6);

    // Saturation of both counters
    do_reset();
    evt_ready = 1'b0; current_in = '0;
    tick = 1'b1; cyc(700); tick = 1'b0; cyc(6);
    chk("ovr_sat", int'(overrun_cnt), 255);
    chk("drop_sat", int'(drop_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
